pwm_peripheral: RTL and testbench

Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs. It sits directly downstream of the SPI register block. Each channel is either forced low, forced high, or driven by one shared 8-bit PWM waveform. The duty cycle is double-buffered so that it only changes on a period boundary, which keeps the waveform glitch-free.

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_prescaler.sv | 32 +++
 rtl/pwm_peripheral.sv | 81 ++++++++
 tb/tb_pwm_peripheral.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, constants and helpers for the PWM peripheral.
//   PWM_CNT_W  - width of the PWM period counter and duty registers
//   NUM_CH     - number of chip output channels
//   DUTY_FULL  - duty code that forces the PWM level high for the whole period
//   ch_mode_e  - per-channel drive mode decoded from the two enable bits
//   prescale_w - prescaler counter width for a given PRESCALE
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam int NUM_CH    = 16;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef enum logic [1:0] {
    CH_OFF,
    CH_HIGH,
    CH_PWM
  } ch_mode_e;

  // $clog2 of the divide ratio, floored at 1 bit so PRESCALE=1 still
  // yields a legal (constant-zero) counter.
  function automatic int prescale_w(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

  function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
    if (!en_out) return CH_OFF;
    return en_pwm ? CH_PWM : CH_HIGH;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk by PRESCALE to produce the PWM counter step.
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   tick  - combinational, high in the last cycle of each PRESCALE-cycle window
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = prescale_w(PRESCALE);
  localparam logic [W-1:0] PSC_MAX = W'(PRESCALE - 1);

  logic [W-1:0] psc;

  assign tick = (psc == PSC_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (tick) begin
      psc <= '0;
    end else begin
      psc <= psc + W'(1);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives the 16 chip outputs from the SPI configuration
// registers. Each channel is off, forced high, or follows one shared 8-bit
// PWM waveform whose duty is reloaded only at the period wrap.
//   clk, rst_n        - system clock, synchronous active-low reset
//   en_reg_out_*      - per-channel output enable (0 forces the pin low)
//   en_reg_pwm_*      - per-channel PWM select (only when output enabled)
//   pwm_duty_cycle    - requested duty, 0x00 = 0%, 0xFF = 100%
//   out               - registered channel outputs
//   period_start      - registered one-clk pulse at the start of each period
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic                  tick;
  logic                  period_wrap;
  logic                  pwm_level;
  logic [PWM_CNT_W-1:0]  pwm_cnt;
  logic [PWM_CNT_W-1:0]  duty_shadow;
  logic [NUM_CH-1:0]     en_out;
  logic [NUM_CH-1:0]     en_pwm;
  logic [NUM_CH-1:0]     out_next;

  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign en_out      = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign period_wrap = tick && (pwm_cnt == '1);

  // 0xFF is special-cased so full duty has no low cycle at the wrap.
  always_comb begin
    pwm_level = (duty_shadow == DUTY_FULL) || (pwm_cnt < duty_shadow);
  end

  always_comb begin
    out_next = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      case (ch_mode(en_out[i], en_pwm[i]))
        CH_HIGH: out_next[i] = 1'b1;
        CH_PWM:  out_next[i] = pwm_level;
        default: out_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      duty_shadow  <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
      end
      if (period_wrap) begin
        duty_shadow <= pwm_duty_cycle;
      end
      out          <= out_next;
      period_start <= period_wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scoreboard bench for pwm_peripheral. The stimulus
// process pushes cycle-tagged expectations (output pattern, period_start
// value, or high-time of out[0] over the period ending at that cycle); the
// monitor samples on the falling edge and pops/compares matching entries.
module tb_pwm_peripheral;

  localparam int unsigned P = 13;
  localparam int unsigned L = 256 * P;

  localparam int unsigned K_OUT = 0;
  localparam int unsigned K_PS  = 1;
  localparam int unsigned K_HI  = 2;

  typedef struct {
    int unsigned cyc;
    int unsigned kind;
    logic [15:0] mask;
    logic [15:0] val;
    int unsigned hi;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int unsigned cyc = 0;
  int unsigned hi_acc = 0;
  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  exp_t  exp_q[$];
  string name_q[$];

  pwm_peripheral #(
    .PRESCALE(P)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .out            (out),
    .period_start   (period_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int unsigned c, input string nm, input int unsigned kind,
                      input logic [15:0] mask, input logic [15:0] val, input int unsigned hi);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.mask = mask;
    e.val  = val;
    e.hi   = hi;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic exp_out(input int unsigned c, input string nm, input logic [15:0] val);
    push(c, nm, K_OUT, 16'hFFFF, val, 0);
  endtask

  task automatic exp_ps(input int unsigned c, input string nm, input logic ps);
    push(c, nm, K_PS, 16'h0001, {15'd0, ps}, 0);
  endtask

  task automatic exp_hi(input int unsigned c, input string nm, input int unsigned hi);
    push(c, nm, K_HI, 16'h0000, 16'h0000, hi);
  endtask

  // Returns #1 after the posedge that brings cyc to c.
  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: high-time window for out[0] is (previous period_start, this one].
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    hi_acc = hi_acc + ((out[0] === 1'b1) ? 1 : 0);
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_assert++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check scheduled for cycle %0d not reached (now %0d)", nm, e.cyc, cyc);
      end else if (e.kind == K_OUT) begin
        if ((out & e.mask) !== (e.val & e.mask)) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: out=%h expected %h", nm, cyc, out, e.val);
        end
      end else if (e.kind == K_PS) begin
        if (period_start !== e.val[0]) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: period_start=%b expected %b", nm, cyc, period_start, e.val[0]);
        end
      end else begin
        if (hi_acc != e.hi) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: out[0] high for %0d clk, expected %0d", nm, cyc, hi_acc, e.hi);
        end
      end
    end
    if (period_start === 1'b1) hi_acc = 0;
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int unsigned ps_at(input int unsigned base, input int unsigned k);
    return base + k * L;
  endfunction

  initial begin
    int unsigned r, t, x, last;

    rst_n           = 1'b0;
    en_reg_out_7_0  = 8'hFF;
    en_reg_out_15_8 = 8'hFF;
    en_reg_pwm_7_0  = 8'hFF;
    en_reg_pwm_15_8 = 8'hFF;
    pwm_duty_cycle  = 8'h80;

    // Reset held for 5 clk; the reset state is the state after edge r.
    for (int unsigned c = 1; c <= 5; c++) begin
      exp_out(c, "reset_out", 16'h0000);
      exp_ps(c, "reset_ps", 1'b0);
    end
    r = 5;
    exp_out(r + 1, "idle_first", 16'h0000);
    exp_out(r + L / 2, "idle_mid", 16'h0000);
    exp_ps(r + L - 1, "no_early_ps", 1'b0);
    exp_out(ps_at(r, 1), "idle_last", 16'h0000);
    exp_ps(ps_at(r, 1), "first_ps", 1'b1);
    exp_ps(ps_at(r, 1) + 1, "ps_one_clk", 1'b0);
    exp_out(ps_at(r, 1) + 1, "first_pwm_rise", 16'hFFFF);
    wait_cyc(5);
    rst_n = 1'b1;

    // Static drive while the PWM level is low (pwm_cnt ~153 vs duty 0x80).
    t = ps_at(r, 1) + 2000;
    exp_out(t, "pwm_low", 16'h0000);
    exp_out(t + 1, "static_high", 16'hFFFF);
    exp_out(t + 2, "upper_disable", 16'h00FF);
    exp_out(t + 3, "ch0_pwm_low", 16'h0000);
    wait_cyc(t);
    en_reg_pwm_7_0  = 8'h00;
    en_reg_pwm_15_8 = 8'h00;
    wait_cyc(t + 1);
    en_reg_out_15_8 = 8'h00;
    wait_cyc(t + 2);
    en_reg_out_7_0 = 8'h01;
    en_reg_pwm_7_0 = 8'h01;

    // 50% duty on channel 0.
    exp_out(ps_at(r, 2), "low_at_wrap", 16'h0000);
    exp_ps(ps_at(r, 2), "ps2", 1'b1);
    exp_out(ps_at(r, 2) + 1, "d50_rise", 16'h0001);
    exp_out(ps_at(r, 2) + 128 * P, "d50_last_high", 16'h0001);
    exp_out(ps_at(r, 2) + 128 * P + 1, "d50_fall", 16'h0000);
    exp_hi(ps_at(r, 3), "d50_high_time", 128 * P);
    exp_ps(ps_at(r, 3), "ps3", 1'b1);
    exp_hi(ps_at(r, 4), "d50_high_time2", 128 * P);
    exp_hi(ps_at(r, 5), "d0_high_time1", 0);
    exp_hi(ps_at(r, 6), "d0_high_time2", 0);
    exp_hi(ps_at(r, 7), "d0_high_time3", 0);
    exp_out(ps_at(r, 7), "d0_last", 16'h0000);
    wait_cyc(ps_at(r, 3) + 10);
    pwm_duty_cycle = 8'h00;

    // Full duty: no low cycle at the wrap.
    exp_out(ps_at(r, 7) + 1, "dff_rise", 16'h0001);
    exp_hi(ps_at(r, 8), "dff_high_time1", L);
    exp_out(ps_at(r, 8), "dff_wrap_high", 16'h0001);
    exp_out(ps_at(r, 8) + 1, "dff_after_wrap", 16'h0001);
    exp_hi(ps_at(r, 9), "dff_high_time2", L);
    exp_hi(ps_at(r, 10), "dff_high_time3", L);
    wait_cyc(ps_at(r, 6) + 10);
    pwm_duty_cycle = 8'hFF;

    // Shadowing: 0x40 active, 0xC0 written mid-period at pwm_cnt=0x10.
    wait_cyc(ps_at(r, 9) + 10);
    pwm_duty_cycle = 8'h40;
    exp_out(ps_at(r, 10) + 64 * P, "d40_last_high", 16'h0001);
    exp_out(ps_at(r, 10) + 64 * P + 1, "d40_fall", 16'h0000);
    exp_hi(ps_at(r, 11), "shadow_current", 64 * P);
    wait_cyc(ps_at(r, 10) + 210);
    pwm_duty_cycle = 8'hC0;
    exp_out(ps_at(r, 11) + 192 * P, "dc0_last_high", 16'h0001);
    exp_out(ps_at(r, 11) + 192 * P + 1, "dc0_fall", 16'h0000);
    exp_hi(ps_at(r, 12), "shadow_next", 192 * P);

    // Reset while out[0] is high at pwm_cnt=0x20.
    x = ps_at(r, 12) + 419;
    exp_out(x - 1, "pre_reset_high", 16'h0001);
    exp_out(x, "mid_reset_out", 16'h0000);
    exp_ps(x, "mid_reset_ps", 1'b0);
    exp_out(x + 1, "post_reset_low", 16'h0000);
    exp_ps(ps_at(r, 13), "no_stale_ps", 1'b0);
    exp_ps(x + L - 1, "no_early_ps2", 1'b0);
    exp_ps(x + L, "ps_after_reset", 1'b1);
    exp_out(x + L, "low_until_reload", 16'h0000);
    exp_out(x + L + 1, "d10_rise", 16'h0001);
    exp_out(x + L + 16 * P, "d10_last_high", 16'h0001);
    exp_out(x + L + 16 * P + 1, "d10_fall", 16'h0000);
    last = x + L + 16 * P + 1;
    wait_cyc(x - 1);
    rst_n = 1'b0;
    pwm_duty_cycle = 8'h10;
    wait_cyc(x);
    rst_n = 1'b1;

    wait_cyc(last + 2);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
